// File: rtl/mux4_feeder.sv
// ============================================================================
// Module   : mux4_feeder
// Purpose  : Source stage for a 4:1 multiplexer. A free-running WIDTH-bit
//            up-counter supplies the 2-bit select from bits [28:27]. A
//            double-buffered nibble supplies the four data inputs. New data
//            is accepted over valid/ready into a pending slot. It is copied
//            to the active slot only at a select wrap boundary, so the
//            multiplexer never sees its data change mid-sweep.
// Ports    : clk, rst_n (async, active-low)
//            en, clr, load, load_val   - counter control (clr > load > en)
//            data_in, data_valid       - nibble handshake input
//            data_ready                - pending slot is empty
//            i0..i3                    - active data bits (active[0..3])
//            sel                       - cnt[28:27]
//            cnt                       - current counter value
//            wrap                      - one-cycle pulse after a boundary
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_feeder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [3:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             i0,
  output logic             i1,
  output logic             i2,
  output logic             i3,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q,       cnt_d;
  logic [3:0]       pending_q,   pending_d;
  logic             pend_full_q, pend_full_d;
  logic [3:0]       active_q,    active_d;
  logic             wrap_q,      wrap_d;

  logic             boundary;
  logic             accept;

  // A boundary is an enabled increment out of cnt[28:0] == all ones.
  // Only an increment counts, so clr or load jumping sel from 3 to 0 is
  // not a boundary. A full WIDTH rollover also satisfies this condition.
  assign boundary = en && !clr && !load && (&cnt_q[28:0]);
  assign accept   = data_valid && !pend_full_q;

  // Counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  // Buffer next state. Accept and transfer cannot both act on pending in
  // the same cycle: accept requires an empty slot, and transfer requires a
  // full one. When a nibble is accepted on a boundary, the pending slot was
  // empty, so active holds and the new nibble waits for the next boundary.
  always_comb begin
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    wrap_d      = boundary;
    if (boundary && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pending_d   = data_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pending_q   <= 4'h0;
      pend_full_q <= 1'b0;
      active_q    <= 4'h0;
      wrap_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      wrap_q      <= wrap_d;
    end
  end

  // All outputs come straight from registers.
  assign cnt        = cnt_q;
  assign sel        = cnt_q[28:27];
  assign data_ready = !pend_full_q;
  assign i0         = active_q[0];
  assign i1         = active_q[1];
  assign i2         = active_q[2];
  assign i3         = active_q[3];
  assign wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_feeder.sv
// ============================================================================
// Module   : tb_mux4_feeder
// Purpose  : Directed self-checking bench for mux4_feeder. Inputs are driven
//            1 time unit after the rising edge; outputs are sampled at the
//            same point, away from the active edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_feeder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, clr, load, data_valid;
  logic [WIDTH-1:0] load_val;
  logic [3:0]       data_in;
  logic             data_ready, i0, i1, i2, i3, wrap;
  logic [1:0]       sel;
  logic [WIDTH-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux4_feeder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .i0         (i0),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .sel        (sel),
    .cnt        (cnt),
    .wrap       (wrap)
  );

  wire [3:0] act = {i3, i2, i1, i0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; load = 0; load_val = '0; data_in = 4'h0; data_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    // Some activity: count and fill the pending slot.
    en = 1; data_in = 4'h9; data_valid = 1;
    step();
    data_valid = 0;
    step();
    step();
    n_cmp++; if (cnt !== 32'd3) begin n_bad++; $display("FAIL pre_reset_cnt: got %h want %h", cnt, 32'd3); end
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL pre_reset_ready: got %b want 0", data_ready); end
    // Asynchronous reset in the middle of a cycle, checked before any edge.
    #2 rst_n = 0;
    #1;
    n_cmp++; if (cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", cnt); end
    n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_cmp++; if (act !== 4'h0) begin n_bad++; $display("FAIL reset_active: got %h want 0", act); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    en = 0;
    step();
    rst_n = 1;
    step();
    n_cmp++; if (cnt !== 32'd0 || data_ready !== 1'b1) begin n_bad++; $display("FAIL release_state: got cnt=%h rdy=%b want 0/1", cnt, data_ready); end
  endtask

  task automatic test_priority();
    load = 1; load_val = 32'd5;
    step();
    n_cmp++; if (cnt !== 32'd5) begin n_bad++; $display("FAIL prio_load5: got %h want 5", cnt); end
    clr = 1; load = 1; load_val = 32'h100; en = 1;
    step();
    n_cmp++; if (cnt !== 32'd0) begin n_bad++; $display("FAIL prio_clr: got %h want 0", cnt); end
    clr = 0;
    step();
    n_cmp++; if (cnt !== 32'h100) begin n_bad++; $display("FAIL prio_load: got %h want 100", cnt); end
    load = 0;
    step();
    n_cmp++; if (cnt !== 32'h101) begin n_bad++; $display("FAIL prio_en: got %h want 101", cnt); end
    en = 0;
    step();
    n_cmp++; if (cnt !== 32'h101) begin n_bad++; $display("FAIL prio_hold: got %h want 101", cnt); end
  endtask

  task automatic test_handshake();
    data_in = 4'hA; data_valid = 1;
    step();
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ready_fall: got %b want 0", data_ready); end
    n_cmp++; if (act !== 4'h0) begin n_bad++; $display("FAIL hs_active_hold: got %h want 0", act); end
    data_in = 4'h5;
    step();
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ignored: got %b want 0", data_ready); end
    data_valid = 0; data_in = 4'h0;
  endtask

  task automatic test_boundary();
    load = 1; load_val = 32'h1FFF_FFFE;
    step();
    load = 0; en = 1;
    step();
    n_cmp++; if (cnt !== 32'h1FFF_FFFF || sel !== 2'd3) begin n_bad++; $display("FAIL bnd_pre: got cnt=%h sel=%0d want 1fffffff/3", cnt, sel); end
    n_cmp++; if (act !== 4'h0 || wrap !== 1'b0) begin n_bad++; $display("FAIL bnd_pre_act: got act=%h wrap=%b want 0/0", act, wrap); end
    step();
    n_cmp++; if (cnt !== 32'h2000_0000 || sel !== 2'd0) begin n_bad++; $display("FAIL bnd_cnt: got cnt=%h sel=%0d want 20000000/0", cnt, sel); end
    n_cmp++; if (act !== 4'hA) begin n_bad++; $display("FAIL bnd_transfer: got %h want a", act); end
    n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_ready: got %b want 1", data_ready); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL bnd_wrap: got %b want 1", wrap); end
    en = 0;
    step();
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL bnd_wrap_pulse: got %b want 0", wrap); end
  endtask

  task automatic test_simultaneous();
    load = 1; load_val = 32'h1FFF_FFFF;
    step();
    load = 0; en = 1; data_valid = 1; data_in = 4'h3;
    step();
    data_valid = 0; en = 0;
    n_cmp++; if (act !== 4'hA) begin n_bad++; $display("FAIL sim_active_hold: got %h want a", act); end
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL sim_pend_full: got %b want 0", data_ready); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL sim_wrap: got %b want 1", wrap); end
    step();
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL sim_wrap_pulse: got %b want 0", wrap); end
    load = 1; load_val = 32'h1FFF_FFFF;
    step();
    load = 0; en = 1;
    step();
    en = 0;
    n_cmp++; if (act !== 4'h3 || data_ready !== 1'b1) begin n_bad++; $display("FAIL sim_next_bnd: got act=%h rdy=%b want 3/1", act, data_ready); end
  endtask

  task automatic test_rollover();
    data_valid = 1; data_in = 4'hC;
    load = 1; load_val = 32'hFFFF_FFFF;
    step();
    data_valid = 0; load = 0; en = 1;
    step();
    en = 0;
    n_cmp++; if (cnt !== 32'd0) begin n_bad++; $display("FAIL roll_cnt: got %h want 0", cnt); end
    n_cmp++; if (act !== 4'hC || data_ready !== 1'b1) begin n_bad++; $display("FAIL roll_transfer: got act=%h rdy=%b want c/1", act, data_ready); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL roll_wrap: got %b want 1", wrap); end
  endtask

  task automatic test_nonboundary();
    data_valid = 1; data_in = 4'h6;
    load = 1; load_val = 32'h1800_0000;
    step();
    data_valid = 0;
    n_cmp++; if (sel !== 2'd3) begin n_bad++; $display("FAIL nb_sel3: got %0d want 3", sel); end
    // Load 0 with en high: load wins, so no boundary.
    load_val = 32'h0; en = 1;
    step();
    load = 0; en = 0;
    n_cmp++; if (cnt !== 32'd0 || wrap !== 1'b0) begin n_bad++; $display("FAIL nb_load: got cnt=%h wrap=%b want 0/0", cnt, wrap); end
    n_cmp++; if (act !== 4'hC || data_ready !== 1'b0) begin n_bad++; $display("FAIL nb_no_transfer: got act=%h rdy=%b want c/0", act, data_ready); end
    // Same from sel=3 with all lower bits set, using clr.
    load = 1; load_val = 32'h1FFF_FFFF;
    step();
    load = 0; clr = 1; en = 1;
    step();
    clr = 0; en = 0;
    n_cmp++; if (cnt !== 32'd0 || wrap !== 1'b0 || act !== 4'hC) begin n_bad++; $display("FAIL nb_clr: got cnt=%h wrap=%b act=%h want 0/0/c", cnt, wrap, act); end
    step();
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL nb_wrap_after: got %b want 0", wrap); end
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    test_reset();
    test_priority();
    test_handshake();
    test_boundary();
    test_simultaneous();
    test_rollover();
    test_nonboundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux4_feeder.md
# mux4_feeder

Upstream source stage for the 4:1 multiplexer. It keeps a free-running WIDTH-bit up-counter whose bits [28:27] drive the multiplexer's 2-bit select. It also provides the four data inputs i0..i3 from a double-buffered 4-bit register. New data is accepted over a valid/ready handshake and becomes visible only at a select wrap boundary, so the multiplexer never sees data change mid-sweep.

## Interface
- WIDTH, 32, counter width; must be >= 29.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  counter increment enable.
- clr  in  1  synchronous counter clear.
- load  in  1  synchronous counter load.
- load_val  in  WIDTH  value written on load.
- data_in  in  4  next data nibble; bit k goes to output ik.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  pending buffer is empty; a nibble can be accepted.
- i0, i1, i2, i3  out  1 each  active data bits; connect to the multiplexer inputs.
- sel  out  2  equals cnt[28:27]; connect to the multiplexer select.
- cnt  out  WIDTH  current counter value.
- wrap  out  1  registered one-cycle pulse marking a boundary.

## Operation
- Counter priority per cycle is clr, then load, then en:
  - clr: cnt <= 0.
  - else load: cnt <= load_val.
  - else en: cnt <= cnt + 1, modulo 2^WIDTH.
  - else hold.
- Boundary: a cycle where en=1, clr=0, load=0 and cnt[28:0] == all ones. In that cycle cnt[28:27] steps from 3 to 0.
  - clr or load never creates a boundary, even if sel jumps from 3 to 0.
  - Full WIDTH rollover (all ones to 0) is also a boundary.
- Buffer state: pending[3:0], pend_full, active[3:0].
  - i0..i3 = active[0..3].
  - data_ready = !pend_full, a direct function of the register.
- Accept: data_valid && data_ready gives pending <= data_in and pend_full <= 1.
  - data_valid while data_ready=0 is ignored. The source must hold the nibble until it is accepted.
- Transfer on a boundary with pend_full=1: active <= pending and pend_full <= 0.
  - Boundary with pend_full=0: active holds.
- Accept and boundary in the same cycle (only possible when pend_full=0): pending fills and active holds. The new nibble waits for the next boundary.
- wrap <= 1 in the cycle after a boundary (registered), else 0. wrap ignores pend_full.
- clr and load act on the counter only; the buffer and handshake are unaffected.

## Timing
- Reset (rst_n=0, asynchronous):
  - cnt=0, sel=0, active=0 (i0..i3=0), pending=0, pend_full=0, wrap=0.
  - data_ready=1 throughout reset and at release.
- Release: the first edge with rst_n=1 is a normal cycle.
- Reset mid-operation: all state returns to reset values immediately, with no clock needed. Any pending nibble is lost.
- Latency:
  - cnt/sel update one edge after en/clr/load.
  - data_ready falls one edge after acceptance.
  - i0..i3 change on the boundary edge.
  - data_ready rises on that same edge; wrap is high for the following cycle.
- Throughput: at most one nibble per boundary period, i.e. one per 2^29 enabled increments.
- No combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: rst_n=0 asynchronously mid-cycle after activity.
  - Required: cnt=0, sel=0, i0..i3=0, wrap=0, data_ready=1 immediately.
- Counter priority:
  - Stimulus: cnt=5; apply clr=1, load=1, load_val=0x100, en=1.
  - Required: cnt=0. Then clr=0 gives cnt=0x100. Then load=0 gives cnt=0x101.
- Handshake:
  - Stimulus: data_in=0xA, data_valid=1.
  - Required: data_ready=0 next cycle, i0..i3 still 0. A second data_valid with 0x5 is ignored, and pending stays 0xA.
- Boundary transfer:
  - Stimulus: load 0x1FFF_FFFE with 0xA pending, then en=1 for 2 cycles.
  - Required: cnt=0x1FFF_FFFF with sel=3, then cnt=0x2000_0000 with sel=0.
  - On that edge, {i3,i2,i1,i0}=0xA and data_ready=1; wrap=1 for the next cycle.
- Simultaneous accept and boundary:
  - Stimulus: pend_full=0, cnt=0x1FFF_FFFF, en=1, data_valid=1 with data_in=0x3.
  - Required: active unchanged, pend_full=1, wrap=1 next cycle. 0x3 appears only at the next boundary.
- Full rollover:
  - Stimulus: load 0xFFFF_FFFF, en=1.
  - Required: cnt=0, boundary taken, wrap=1 next cycle.
- Non-boundary load:
  - Stimulus: load 0x0000_0000 while sel=3.
  - Required: no transfer, wrap stays 0.
